// File: rtl/ram_dma_engine_pkg.sv
// Shared constants for the RAM block-move engine: state encoding, command modes, default widths.
package ram_dma_engine_pkg;

  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_READ  = 2'd1;
  localparam state_t ST_WRITE = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/ram_dma_engine_if.sv
// Command and memory-port bundle between the block-move engine and its environment.
interface ram_dma_engine_if #(
  parameter int ADDR_W = ram_dma_engine_pkg::ADDR_W_DEF,
  parameter int DATA_W = ram_dma_engine_pkg::DATA_W_DEF
);
  // Handshake: start is a one-shot request taken only on an edge where the engine is
  // idle (busy=0 and done=0); there is no ready back-pressure and no queueing, so a
  // requester must see busy/done low before relying on acceptance. done pulses once.
  logic              start;
  logic              mode;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [ADDR_W:0]   length;
  logic [DATA_W-1:0] fill_value;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_load;
  logic [DATA_W-1:0] mem_rdata;
  logic [1:0]        dbg_state;

  modport master (
    input  start, mode, src_addr, dst_addr, length, fill_value, mem_rdata,
    output busy, done, mem_address, mem_wdata, mem_load, dbg_state
  );

  modport slave (
    output start, mode, src_addr, dst_addr, length, fill_value, mem_rdata,
    input  busy, done, mem_address, mem_wdata, mem_load, dbg_state
  );
endinterface

// File: rtl/ram_dma_engine.sv
// Block COPY/FILL engine driving a single-port RAM with combinational read.
module ram_dma_engine
  import ram_dma_engine_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  ram_dma_engine_if.master bus
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              mode_q, mode_d;
  logic              last_word;

  // idx is one bit narrower than len, so a full-space command still ends on idx = 2**ADDR_W-1.
  assign last_word = ({1'b0, idx_q} == (len_q - {{ADDR_W{1'b0}}, 1'b1}));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    src_d   = src_q;
    dst_d   = dst_q;
    fill_d  = fill_q;
    data_d  = data_q;
    mode_d  = mode_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          idx_d  = '0;
          len_d  = bus.length;
          src_d  = bus.src_addr;
          dst_d  = bus.dst_addr;
          fill_d = bus.fill_value;
          mode_d = bus.mode;
          if (bus.length == '0)           state_d = ST_DONE;
          else if (bus.mode == MODE_FILL) state_d = ST_WRITE;
          else                            state_d = ST_READ;
        end
      end
      ST_READ: begin
        data_d  = bus.mem_rdata;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (last_word) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = (mode_q == MODE_FILL) ? ST_WRITE : ST_READ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      fill_q  <= '0;
      data_q  <= '0;
      mode_q  <= MODE_COPY;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      fill_q  <= fill_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
    end
  end

  // Outputs decode only registered state, so reset forces mem_load low on the very next cycle.
  always_comb begin
    bus.mem_address = '0;
    bus.mem_wdata   = '0;
    bus.mem_load    = 1'b0;
    case (state_q)
      ST_READ:  bus.mem_address = src_q + idx_q;
      ST_WRITE: begin
        bus.mem_address = dst_q + idx_q;
        bus.mem_wdata   = (mode_q == MODE_FILL) ? fill_q : data_q;
        bus.mem_load    = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.busy      = (state_q == ST_READ) || (state_q == ST_WRITE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_ram_dma_engine.sv
// Bench for ram_dma_engine: RAM model, directed and random commands checked against a word-level reference memory.
module tb_ram_dma_engine;
  import ram_dma_engine_pkg::*;

  localparam int AW    = 14;
  localparam int DW    = 16;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ram_dma_engine_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ram_dma_engine #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // RAM16K-style memory: combinational read, write on posedge when load is high.
  logic [DW-1:0] ram     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];

  assign bus.mem_rdata = ram[bus.mem_address];
  always @(posedge clk) if (bus.mem_load) ram[bus.mem_address] <= bus.mem_wdata;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: words move one at a time in ascending order, addresses wrap modulo the space.
  task automatic ref_apply(input logic mode, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                           input int len, input logic [DW-1:0] fill);
    for (int i = 0; i < len; i++) begin
      logic [AW-1:0] s, d;
      s = src + AW'(i);
      d = dst + AW'(i);
      ref_mem[d] = mode ? fill : ref_mem[s];
    end
  endtask

  task automatic compare_mem(input string tag);
    int bad;
    int first;
    bad   = 0;
    first = -1;
    for (int a = 0; a < DEPTH; a++) begin
      if (ram[a] !== ref_mem[a]) begin
        bad++;
        if (first < 0) first = a;
      end
    end
    if (first >= 0) $display("%s: first differing word at 0x%0h ram=0x%0h ref=0x%0h",
                             tag, first, ram[first], ref_mem[first]);
    check({tag, "_mem_diffs"}, bad, 0);
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] v);
    @(negedge clk);
    ram[a]     <= v;
    ref_mem[a]  = v;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},   bus.busy,        1'b0);
    check({tag, "_done"},   bus.done,        1'b0);
    check({tag, "_load"},   bus.mem_load,    1'b0);
    check({tag, "_addr"},   bus.mem_address, '0);
    check({tag, "_wdata"},  bus.mem_wdata,   '0);
  endtask

  task automatic run_cmd(input string tag, input logic mode, input logic [AW-1:0] src,
                         input logic [AW-1:0] dst, input int len, input logic [DW-1:0] fill,
                         input int hold);
    int exp_lat, lat, loads, busy_cyc, k, budget;
    exp_lat  = (len == 0) ? 1 : (mode ? len + 1 : 2 * len + 1);
    lat      = -1;
    loads    = 0;
    busy_cyc = 0;
    k        = 0;
    budget   = exp_lat + 20;
    @(negedge clk);
    bus.start      = 1'b1;
    bus.mode       = mode;
    bus.src_addr   = src;
    bus.dst_addr   = dst;
    bus.length     = (AW+1)'(len);
    bus.fill_value = fill;
    @(posedge clk);
    while (lat < 0 && k < budget) begin
      @(negedge clk);
      k++;
      if (k >= hold) begin
        bus.start      = 1'b0;
        bus.mode       = 1'($urandom);
        bus.src_addr   = AW'($urandom);
        bus.dst_addr   = AW'($urandom);
        bus.length     = (AW+1)'($urandom);
        bus.fill_value = DW'($urandom);
      end
      if (bus.mem_load) loads++;
      if (bus.busy) busy_cyc++;
      if (bus.done) lat = k;
    end
    bus.start = 1'b0;
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_loads"}, loads, len);
    check({tag, "_busy_cycles"}, busy_cyc, exp_lat - 1);
    @(negedge clk);
    check({tag, "_done_pulse"}, bus.done, 1'b0);
    check({tag, "_idle_after"}, bus.busy, 1'b0);
    ref_apply(mode, src, dst, len, fill);
    compare_mem(tag);
  endtask

  initial begin
    int loads, dones;
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.mode       = MODE_COPY;
    bus.src_addr   = '0;
    bus.dst_addr   = '0;
    bus.length     = '0;
    bus.fill_value = '0;
    for (int a = 0; a < DEPTH; a++) begin
      logic [DW-1:0] v;
      v          = DW'($urandom);
      ram[a]    <= v;
      ref_mem[a] = v;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    check("reset_state", bus.dbg_state, ST_IDLE);
    reset = 1'b0;

    run_cmd("fill_basic", MODE_FILL, '0, 14'h0100, 4, 16'hBEEF, 1);
    check("fill_basic_word0", ram[14'h0100], 16'hBEEF);
    check("fill_basic_word3", ram[14'h0103], 16'hBEEF);
    check("fill_basic_next_kept", ram[14'h0104], ref_mem[14'h0104]);

    poke(14'h0010, 16'd1);
    poke(14'h0011, 16'd2);
    poke(14'h0012, 16'd3);
    run_cmd("copy_basic", MODE_COPY, 14'h0010, 14'h0200, 3, '0, 1);
    check("copy_basic_w0", ram[14'h0200], 16'd1);
    check("copy_basic_w2", ram[14'h0202], 16'd3);

    run_cmd("fill_wrap", MODE_FILL, '0, 14'h3FFE, 4, 16'h1234, 1);
    check("fill_wrap_top", ram[14'h3FFF], 16'h1234);
    check("fill_wrap_low", ram[14'h0001], 16'h1234);

    run_cmd("len_zero", MODE_COPY, 14'h0005, 14'h0006, 0, '0, 1);
    run_cmd("start_held", MODE_FILL, '0, 14'h0400, 3, 16'hC0DE, 4);

    poke(14'h0020, 16'h000A);
    run_cmd("overlap", MODE_COPY, 14'h0020, 14'h0021, 3, '0, 1);
    check("overlap_w1", ram[14'h0021], 16'h000A);
    check("overlap_w3", ram[14'h0023], 16'h000A);

    // Abort during WRITE: the first three fill words land, nothing after.
    @(negedge clk);
    bus.start      = 1'b1;
    bus.mode       = MODE_FILL;
    bus.dst_addr   = 14'h0300;
    bus.length     = 15'd8;
    bus.fill_value = 16'h5A5A;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_in_write", bus.mem_load, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check_idle("abort");
    reset = 1'b0;
    loads = 0;
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.mem_load) loads++;
      if (bus.done) dones++;
    end
    check("abort_no_loads", loads, 0);
    check("abort_no_done", dones, 0);
    ref_apply(MODE_FILL, '0, 14'h0300, 3, 16'h5A5A);
    compare_mem("abort");

    for (int n = 0; n < 12; n++) begin
      logic          m;
      logic [AW-1:0] s, d;
      int            len;
      m   = 1'($urandom);
      s   = AW'($urandom);
      d   = (n % 3 == 0) ? s + AW'($urandom_range(1, 4)) : AW'($urandom);
      len = (n == 5) ? 1 : $urandom_range(0, 48);
      run_cmd($sformatf("rand%0d", n), m, s, d, len, DW'($urandom), $urandom_range(1, 2));
    end

    run_cmd("fill_full", MODE_FILL, '0, AW'($urandom), DEPTH, DW'($urandom), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
